// File: rtl/mc_control_unit.sv
// Multicycle MIPS control FSM: decodes op/func into ALU control, datapath selects and enables.
// Define MC_CU_ILLEGAL_TRAP_EN to trap unlisted encodings into HALT; otherwise they execute as NOP.
module mc_control_unit #(
    parameter logic [2:0] RESET_STATE = 3'd0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] func,
    input  logic       z,
    input  logic       mem_ready,
    output logic [2:0] state,
    output logic [3:0] aluc,
    output logic [1:0] alusrca,
    output logic [1:0] alusrcb,
    output logic       sext,
    output logic [1:0] pcsource,
    output logic       pc_write,
    output logic       ir_write,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic [1:0] regdst,
    output logic [1:0] wdsel,
    output logic       retire,
    output logic       illegal
);

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EXE  = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_t;

    localparam logic [3:0] ALU_ADD = 4'b0000, ALU_SUB = 4'b0100, ALU_AND = 4'b0001,
                           ALU_OR  = 4'b0101, ALU_XOR = 4'b0010, ALU_LUI = 4'b0110,
                           ALU_SLL = 4'b0011, ALU_SRL = 4'b0111, ALU_SRA = 4'b1111;

    localparam logic [5:0] OP_RTYPE = 6'b000000, OP_J    = 6'b000010, OP_JAL  = 6'b000011,
                           OP_BEQ   = 6'b000100, OP_BNE  = 6'b000101, OP_ADDI = 6'b001000,
                           OP_ANDI  = 6'b001100, OP_ORI  = 6'b001101, OP_XORI = 6'b001110,
                           OP_LUI   = 6'b001111, OP_LW   = 6'b100011, OP_SW   = 6'b101011;

    state_t state_q, state_d;

    logic       is_r, r_alu, r_shift, r_jr, is_imm, is_mem, is_br, is_jump, legal;
    logic [3:0] r_aluc, i_aluc;

    always_ff @(posedge clock) begin
        if (reset) state_q <= state_t'(RESET_STATE);
        else       state_q <= state_d;
    end

    assign state = state_q;

    always_comb begin
        is_r    = (op == OP_RTYPE);
        r_jr    = (func == 6'b001000);
        r_alu   = 1'b1;
        r_shift = 1'b0;
        r_aluc  = ALU_ADD;
        case (func)
            6'b100000: r_aluc = ALU_ADD;
            6'b100010: r_aluc = ALU_SUB;
            6'b100100: r_aluc = ALU_AND;
            6'b100101: r_aluc = ALU_OR;
            6'b100110: r_aluc = ALU_XOR;
            6'b000000: begin r_aluc = ALU_SLL; r_alu = 1'b0; r_shift = 1'b1; end
            6'b000010: begin r_aluc = ALU_SRL; r_alu = 1'b0; r_shift = 1'b1; end
            6'b000011: begin r_aluc = ALU_SRA; r_alu = 1'b0; r_shift = 1'b1; end
            default:   r_alu = 1'b0;
        endcase
        is_imm = 1'b1;
        i_aluc = ALU_ADD;
        case (op)
            OP_ADDI: i_aluc = ALU_ADD;
            OP_ANDI: i_aluc = ALU_AND;
            OP_ORI:  i_aluc = ALU_OR;
            OP_XORI: i_aluc = ALU_XOR;
            OP_LUI:  i_aluc = ALU_LUI;
            default: is_imm = 1'b0;
        endcase
        is_mem  = (op == OP_LW) || (op == OP_SW);
        is_br   = (op == OP_BEQ) || (op == OP_BNE);
        is_jump = (op == OP_J) || (op == OP_JAL);
        legal   = is_r ? (r_alu || r_shift || r_jr) : (is_imm || is_mem || is_br || is_jump);
    end

    always_comb begin
        state_d   = state_q;
        aluc      = ALU_ADD;
        alusrca   = '0;
        alusrcb   = '0;
        sext      = 1'b0;
        pcsource  = '0;
        pc_write  = 1'b0;
        ir_write  = 1'b0;
        iord      = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        reg_write = 1'b0;
        regdst    = '0;
        wdsel     = '0;
        retire    = 1'b0;
        illegal   = 1'b0;
        // Reset overrides everything so an aborted instruction never writes state.
        if (!reset) begin
            case (state_q)
                S_IF: begin
                    mem_read = 1'b1;
                    alusrcb  = 2'd1;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        state_d  = S_ID;
                    end
                end
                S_ID: begin
                    alusrcb = 2'd3;
                    sext    = 1'b1;
                    if (is_jump) begin
                        pcsource = 2'd2;
                        pc_write = 1'b1;
                        retire   = 1'b1;
                        state_d  = S_IF;
                        if (op == OP_JAL) begin
                            reg_write = 1'b1;
                            regdst    = 2'd2;
                            wdsel     = 2'd2;
                        end
                    end else if (is_r && r_jr) begin
                        pcsource = 2'd3;
                        pc_write = 1'b1;
                        retire   = 1'b1;
                        state_d  = S_IF;
                    end else if (legal) begin
                        state_d = S_EXE;
                    end else begin
`ifdef MC_CU_ILLEGAL_TRAP_EN
                        state_d = S_HALT;
`else
                        retire  = 1'b1;
                        state_d = S_IF;
`endif
                    end
                end
                S_EXE: begin
                    state_d = S_IF;
                    if (is_r) begin
                        alusrca = r_shift ? 2'd2 : 2'd1;
                        aluc    = r_aluc;
                        state_d = S_WB;
                    end else if (is_mem) begin
                        alusrca = 2'd1;
                        alusrcb = 2'd2;
                        sext    = 1'b1;
                        state_d = S_MEM;
                    end else if (is_br) begin
                        alusrca  = 2'd1;
                        aluc     = ALU_SUB;
                        pcsource = 2'd1;
                        pc_write = (op == OP_BEQ) ? z : ~z;
                        retire   = 1'b1;
                    end else if (is_imm) begin
                        alusrca = 2'd1;
                        alusrcb = 2'd2;
                        aluc    = i_aluc;
                        sext    = (op == OP_ADDI);
                        state_d = S_WB;
                    end
                end
                S_MEM: begin
                    iord      = 1'b1;
                    mem_read  = (op == OP_LW);
                    mem_write = (op == OP_SW);
                    if (mem_ready) begin
                        retire  = (op == OP_SW);
                        state_d = (op == OP_SW) ? S_IF : S_WB;
                    end
                end
                S_WB: begin
                    reg_write = 1'b1;
                    retire    = 1'b1;
                    regdst    = is_r ? 2'd0 : 2'd1;
                    wdsel     = (op == OP_LW) ? 2'd1 : 2'd0;
                    state_d   = S_IF;
                end
                S_HALT: begin
`ifdef MC_CU_ILLEGAL_TRAP_EN
                    illegal = 1'b1;
`else
                    state_d = S_IF;
`endif
                end
                default: state_d = S_IF;
            endcase
        end
    end

endmodule
